// File: rtl/cipher_frame_ctrl.sv
// rtl/cipher_frame_ctrl.sv - framing front-end for stream_cipher: seed load, payload gating, output re-timing
module cipher_frame_ctrl #(
    parameter int MAX_LEN  = 255,
    parameter int SEED_GAP = 1,
    parameter int LAT      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic        load_seed,
    output logic [7:0]  seed_in,
    output logic        encrypt_en,
    output logic [7:0]  data_in,
    input  logic [7:0]  cipher_dout,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] frame_cnt,
    output logic        err_nosof,
    output logic        err_len
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [15:0] GAP_W     = 16'(SEED_GAP);
    localparam logic [15:0] LAT_W     = 16'(LAT);

    logic [2:0]     state;
    logic [15:0]    len;
    logic [15:0]    wait_cnt;
    logic           rdy_en;
    logic [LAT-1:0] en_sr;
    logic [LAT-1:0] last_sr;
    logic           acc;
    logic           pay_acc;
    logic           pay_last;
    logic           len_hit;

    // rdy_en keeps s_ready low while reset is held, independent of the state decode
    assign s_ready    = rdy_en && (state == S_IDLE || state == S_PAYLOAD || state == S_DISCARD);
    assign encrypt_en = en_sr[0];

    always_comb begin
        acc      = s_valid && s_ready;
        len_hit  = (len + 16'd1) == MAX_LEN_W;
        pay_acc  = acc && (state == S_PAYLOAD);
        pay_last = pay_acc && (s_eof || len_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            wait_cnt  <= '0;
            rdy_en    <= 1'b0;
            en_sr     <= '0;
            last_sr   <= '0;
            load_seed <= 1'b0;
            seed_in   <= '0;
            data_in   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
            err_nosof <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            load_seed <= 1'b0;
            err_nosof <= 1'b0;
            err_len   <= 1'b0;

            // stage 0 is encrypt_en itself; the final stage feeds m_valid and samples cipher_dout
            en_sr[0]   <= pay_acc;
            last_sr[0] <= pay_last;
            for (int i = 1; i < LAT; i++) begin
                en_sr[i]   <= en_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            if (pay_acc) begin
                data_in <= s_data;
            end
            m_valid <= en_sr[LAT-1];
            m_last  <= en_sr[LAT-1] && last_sr[LAT-1];
            if (en_sr[LAT-1]) begin
                m_data <= cipher_dout;
            end

            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (s_sof) begin
                            seed_in   <= s_data;
                            load_seed <= 1'b1;
                            len       <= '0;
                            wait_cnt  <= '0;
                            if (s_eof) begin
                                frame_cnt <= frame_cnt + 16'd1;
                                state     <= S_DRAIN;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            err_nosof <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (wait_cnt == GAP_W) begin
                        state <= S_PAYLOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (acc) begin
                        len <= len + 16'd1;
                        if (s_eof) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            wait_cnt  <= '0;
                            state     <= S_DRAIN;
                        end else if (len_hit) begin
                            err_len   <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (acc && s_eof) begin
                        wait_cnt <= '0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (wait_cnt == LAT_W) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// tb/tb_cipher_frame_ctrl.sv - scoreboard bench for cipher_frame_ctrl with a seed+index keystream cipher model
module tb_cipher_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eof = 1'b0;
    logic        load_seed;
    logic [7:0]  seed_in;
    logic        encrypt_en;
    logic [7:0]  data_in;
    logic [7:0]  cipher_dout;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] frame_cnt;
    logic        err_nosof;
    logic        err_len;

    cipher_frame_ctrl #(.MAX_LEN(4), .SEED_GAP(1), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
        .load_seed(load_seed), .seed_in(seed_in), .encrypt_en(encrypt_en), .data_in(data_in),
        .cipher_dout(cipher_dout),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .frame_cnt(frame_cnt), .err_nosof(err_nosof), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cipher stand-in: registered output, keystream byte i of a frame = seed + i
    logic [7:0] ks;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks          <= '0;
            cipher_dout <= '0;
        end else if (load_seed) begin
            ks <= seed_in;
        end else if (encrypt_en) begin
            cipher_dout <= data_in ^ ks;
            ks          <= ks + 8'd1;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    logic [8:0] exp_q[$];
    int         en_hist[$];
    int         mv_hist[$];
    int         n_load = 0;
    int         n_errlen = 0;
    int         n_errnosof = 0;
    int         last_seed = -1;

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (load_seed) begin
                n_load++;
                last_seed = seed_in;
            end
            if (encrypt_en) en_hist.push_back(cyc);
            if (err_len) n_errlen++;
            if (err_nosof) n_errnosof++;
            if (m_valid) begin
                mv_hist.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_m_valid", m_data, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e[7:0]);
                    check("m_last", m_last, e[8]);
                end
            end
        end
    end

    int acc_e;

    task automatic send(input logic [7:0] d, input logic sof, input logic eof);
        bit ok = 1'b0;
        int n = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end
        #1;
        acc_e = cyc;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    int b_load, b_en, b_mv, b_el, b_en2, acc0, rlow;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_encrypt_en", encrypt_en, 0);
        check("rst_load_seed", load_seed, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // normal three-byte frame, contiguous
        b_load = n_load; b_en = en_hist.size(); b_mv = mv_hist.size();
        expect_out(8'hA5, 1'b0); expect_out(8'hB7, 1'b0); expect_out(8'h85, 1'b1);
        send(8'hA5, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0); acc0 = acc_e;
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        repeat (8) @(posedge clk); #1;
        check("t1_load_cnt", n_load - b_load, 1);
        check("t1_seed", last_seed, 8'hA5);
        check("t1_en_cnt", en_hist.size() - b_en, 3);
        check("t1_en_first", en_hist[b_en], acc0);
        check("t1_en_contig", en_hist[b_en+2] - en_hist[b_en], 2);
        check("t1_mv_first", mv_hist[b_mv], acc0 + 2);
        check("t1_frame_cnt", frame_cnt, 1);

        // empty frame
        b_load = n_load; b_en = en_hist.size(); b_mv = mv_hist.size();
        send(8'h3C, 1'b1, 1'b1);
        rlow = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_ready) break;
            rlow++;
        end
        repeat (6) @(posedge clk); #1;
        check("t3_ready_low", rlow, 3);
        check("t3_load_cnt", n_load - b_load, 1);
        check("t3_seed", last_seed, 8'h3C);
        check("t3_en_cnt", en_hist.size() - b_en, 0);
        check("t3_mv_cnt", mv_hist.size() - b_mv, 0);
        check("t3_frame_cnt", frame_cnt, 2);

        // truncation at MAX_LEN=4
        b_en = en_hist.size(); b_el = n_errlen;
        expect_out(8'h11, 1'b0); expect_out(8'h13, 1'b0);
        expect_out(8'h11, 1'b0); expect_out(8'h17, 1'b1);
        send(8'h10, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, i == 6);
        repeat (8) @(posedge clk); #1;
        check("t4_en_cnt", en_hist.size() - b_en, 4);
        check("t4_err_len", n_errlen - b_el, 1);
        check("t4_frame_cnt", frame_cnt, 3);

        // stray non-sof beat, then a good frame
        b_load = n_load; b_en = en_hist.size(); b_el = n_errnosof;
        send(8'h77, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("t5_err_nosof", n_errnosof - b_el, 1);
        check("t5_no_load", n_load - b_load, 0);
        check("t5_no_en", en_hist.size() - b_en, 0);
        expect_out(8'h75, 1'b0); expect_out(8'h8B, 1'b1);
        send(8'h20, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b1);
        repeat (8) @(posedge clk); #1;
        check("t5_frame_cnt", frame_cnt, 4);
        check("t5_seed", last_seed, 8'h20);

        // reset mid-payload
        b_mv = mv_hist.size();
        send(8'h40, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_en", encrypt_en, 0);
        check("t6_rst_mv", m_valid, 0);
        check("t6_rst_ready", s_ready, 0);
        check("t6_rst_seed", seed_in, 0);
        check("t6_rst_frame_cnt", frame_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        b_en2 = en_hist.size();
        expect_out(8'h0E, 1'b0); expect_out(8'hF2, 1'b1);
        send(8'h01, 1'b1, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b1);
        repeat (8) @(posedge clk); #1;
        check("t6_en_cnt", en_hist.size() - b_en2, 2);
        check("t6_mv_cnt", mv_hist.size() - b_mv, 2);
        check("t6_frame_cnt", frame_cnt, 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
